// File: rtl/time_pkg.sv
// Shared definitions for the time-field counter blocks.
//
// Contents:
//   STATE_W            width of the run-control state register
//   state_t            state register type
//   ST_IDLE / ST_RUN / ST_DONE   run-control state encodings
package time_pkg;

  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mod_step.sv
// Combinational +/-1 modulo MODULUS step with wrap indication.
//
// Parameters:
//   MODULUS  count range 0..MODULUS-1
//   WIDTH    width of the count value
// Ports:
//   val_i     current count
//   up_i      1 = step up, 0 = step down
//   nxt_o     stepped count
//   carry_o   step wraps MODULUS-1 -> 0
//   borrow_o  step wraps 0 -> MODULUS-1
module mod_step #(
  parameter int MODULUS = 100,
  parameter int WIDTH   = 7
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             carry_o,
  output logic             borrow_o
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic at_max;
  logic at_zero;

  assign at_max  = (val_i == MAX_VAL);
  assign at_zero = (val_i == '0);

  always_comb begin
    nxt_o    = val_i;
    carry_o  = 1'b0;
    borrow_o = 1'b0;
    if (up_i) begin
      if (at_max) begin
        nxt_o   = '0;
        carry_o = 1'b1;
      end else begin
        nxt_o = val_i + WIDTH'(1);
      end
    end else begin
      if (at_zero) begin
        nxt_o    = MAX_VAL;
        borrow_o = 1'b1;
      end else begin
        nxt_o = val_i - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-MODULUS up/down counter for one time field (stopwatch or countdown),
// with run-control FSM, preset load, manual inc/dec and registered
// carry/borrow pulses for cascading into the next field.
//
// Optional feature macro: TIME_COUNTER_ONESHOT_EN
//   defined   : counting down in RUN stops at zero and enters DONE
//   undefined : no DONE state, down count always wraps, o_done tied 0
//
// State table:
//   state   | meaning
//   ST_IDLE | paused, ticks ignored, inc/dec accepted
//   ST_RUN  | ticks step the count in direction `up`
//   ST_DONE | countdown reached zero, count frozen until clear/load
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   tick      count-step pulse (counted only in RUN)
//   up        direction, 1 = up
//   run       run level
//   clear     synchronous clear to 0 (highest priority)
//   load      synchronous preset from load_val (saturated)
//   load_val  preset value
//   inc/dec   manual step pulses
//   o_time    registered count
//   o_carry   registered wrap-up pulse
//   o_borrow  registered wrap-down pulse
//   o_zero    o_time == 0
//   o_done    registered, FSM in DONE
module mod_updown_counter
  import time_pkg::*;
#(
  parameter int MODULUS = 100,
  parameter int WIDTH   = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             up,
  input  logic             run,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] o_time,
  output logic             o_carry,
  output logic             o_borrow,
  output logic             o_zero,
  output logic             o_done
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;

  logic             tick_step;
  logic             man_step;
  logic             step_up;
  logic [WIDTH-1:0] step_nxt;
  logic             step_carry;
  logic             step_borrow;

  // Ticks only count while already in RUN (decided on the current state,
  // so a tick coinciding with run falling is still counted).
  assign tick_step = tick && (state_q == ST_RUN);
  // inc and dec together cancel out.
  assign man_step  = inc ^ dec;
  // A tick step owns the step path; otherwise the manual direction does.
  assign step_up   = tick_step ? up : inc;

  mod_step #(
    .MODULUS (MODULUS),
    .WIDTH   (WIDTH)
  ) u_step (
    .val_i    (count_q),
    .up_i     (step_up),
    .nxt_o    (step_nxt),
    .carry_o  (step_carry),
    .borrow_o (step_borrow)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (clear) begin
      count_d = '0;
      state_d = ST_IDLE;
    end else if (load) begin
      count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      state_d = ST_IDLE;
`ifdef TIME_COUNTER_ONESHOT_EN
    end else if (state_q == ST_DONE) begin
      // frozen: only clear, load or reset leave DONE
      state_d = ST_DONE;
`endif
    end else begin
      state_d = run ? ST_RUN : ST_IDLE;
`ifdef TIME_COUNTER_ONESHOT_EN
      // Countdown stops at zero instead of wrapping.
      if (tick_step && !up && (count_q <= WIDTH'(1))) begin
        count_d = '0;
        state_d = ST_DONE;
      end else
`endif
      if (tick_step || man_step) begin
        count_d  = step_nxt;
        carry_d  = step_carry;
        borrow_d = step_borrow;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

`ifdef TIME_COUNTER_ONESHOT_EN
  logic done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_d == ST_DONE);
    end
  end

  assign o_done = done_q;
`else
  assign o_done = 1'b0;
`endif

  assign o_time   = count_q;
  assign o_carry  = carry_q;
  assign o_borrow = borrow_q;
  assign o_zero   = (count_q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;

  localparam int M = 100;
  localparam int W = 7;

  logic         clk;
  logic         reset_n;
  logic         tick, up, run, clear, load, inc, dec;
  logic [W-1:0] load_val;
  logic [W-1:0] o_time;
  logic         o_carry, o_borrow, o_zero, o_done;

  mod_updown_counter #(.MODULUS(M), .WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick     (tick),
    .up       (up),
    .run      (run),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .inc      (inc),
    .dec      (dec),
    .o_time   (o_time),
    .o_carry  (o_carry),
    .o_borrow (o_borrow),
    .o_zero   (o_zero),
    .o_done   (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

`ifdef TIME_COUNTER_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  // Reference model: count as an integer, "running" and "done" as flags.
  bit chk_en = 1'b0;
  int m_cnt  = 0;
  bit m_run  = 1'b0;
  bit m_done = 1'b0;
  int n_cnt;
  bit n_run, n_done, n_c, n_b;

  always @(posedge clk) begin
    if (chk_en && reset_n) begin
      n_cnt  = m_cnt;
      n_run  = m_run;
      n_done = m_done;
      n_c    = 1'b0;
      n_b    = 1'b0;
      if (clear) begin
        n_cnt = 0; n_run = 1'b0; n_done = 1'b0;
      end else if (load) begin
        n_cnt = (int'(load_val) >= M) ? M - 1 : int'(load_val);
        n_run = 1'b0; n_done = 1'b0;
      end else if (!m_done) begin
        if (m_run && tick) begin
          if (up) begin
            n_c   = (m_cnt == M - 1);
            n_cnt = (m_cnt + 1) % M;
          end else if (ONESHOT && m_cnt <= 1) begin
            n_cnt  = 0;
            n_done = 1'b1;
          end else begin
            n_b   = (m_cnt == 0);
            n_cnt = (m_cnt + M - 1) % M;
          end
        end else if (inc && !dec) begin
          n_c   = (m_cnt == M - 1);
          n_cnt = (m_cnt + 1) % M;
        end else if (dec && !inc) begin
          n_b   = (m_cnt == 0);
          n_cnt = (m_cnt + M - 1) % M;
        end
        n_run = n_done ? 1'b0 : run;
      end
      #1;
      chk("time",   int'(o_time),   n_cnt);
      chk("carry",  int'(o_carry),  int'(n_c));
      chk("borrow", int'(o_borrow), int'(n_b));
      chk("zero",   int'(o_zero),   int'(n_cnt == 0));
      chk("done",   int'(o_done),   int'(n_done));
      m_cnt  = n_cnt;
      m_run  = n_run;
      m_done = n_done;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    tick = 0; up = 1; run = 0; clear = 0; load = 0; inc = 0; dec = 0;
    load_val = '0;
    #23;
    chk("rst_time",   int'(o_time),   0);
    chk("rst_zero",   int'(o_zero),   1);
    chk("rst_carry",  int'(o_carry),  0);
    chk("rst_borrow", int'(o_borrow), 0);
    chk("rst_done",   int'(o_done),   0);
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    chk_en = 1'b1;

    // Count up through a full wrap.
    run = 1; up = 1;
    step();
    chk("enter_run_time", int'(o_time), 0);
    tick = 1;
    for (int k = 1; k <= 100; k++) begin
      step();
      chk("up_seq", int'(o_time), k % 100);
      chk("up_carry", int'(o_carry), int'(k == 100));
    end
    tick = 0;
    step();
    chk("carry_one_cycle", int'(o_carry), 0);

    // Down from 0 wraps with borrow.
    up = 0; tick = 1;
    step();
    chk("down_wrap_time", int'(o_time), 99);
    chk("down_borrow", int'(o_borrow), 1);
    tick = 0;

    // Saturating load, then ticks while paused.
    run = 0; load = 1; load_val = 7'd120;
    step();
    chk("load_sat", int'(o_time), 99);
    chk("load_no_carry", int'(o_carry), 0);
    load = 0; tick = 1;
    repeat (3) step();
    chk("paused_hold", int'(o_time), 99);
    tick = 0;

    // clear beats load beats tick.
    load = 1; load_val = 7'd42;
    step();
    chk("load42", int'(o_time), 42);
    load = 0; run = 1;
    step();
    clear = 1; load = 1; load_val = 7'd7; tick = 1;
    step();
    chk("clear_prio", int'(o_time), 0);
    chk("clear_no_borrow", int'(o_borrow), 0);
    clear = 0; load = 0; tick = 0; run = 0;

    // Manual inc/dec.
    load = 1; load_val = 7'd5;
    step();
    load = 0; inc = 1; dec = 1;
    step();
    chk("incdec_cancel", int'(o_time), 5);
    inc = 0; dec = 0; load = 1; load_val = 7'd99;
    step();
    load = 0; inc = 1;
    step();
    chk("inc_wrap", int'(o_time), 0);
    chk("inc_carry", int'(o_carry), 1);
    inc = 0;
    step();

`ifdef TIME_COUNTER_ONESHOT_EN
    load = 1; load_val = 7'd3; run = 0;
    step();
    load = 0; run = 1; up = 0;
    step();
    tick = 1;
    step(); chk("os_2", int'(o_time), 2);
    step(); chk("os_1", int'(o_time), 1);
    step(); chk("os_0", int'(o_time), 0);
    chk("os_done", int'(o_done), 1);
    chk("os_no_borrow", int'(o_borrow), 0);
    step(); chk("os_hold", int'(o_time), 0);
    chk("os_done_hold", int'(o_done), 1);
    tick = 0; load = 1; load_val = 7'd10;
    step();
    chk("os_reload_done", int'(o_done), 0);
    chk("os_reload_time", int'(o_time), 10);
    load = 0; run = 0;
    step();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      clear    = ($urandom_range(0, 31) == 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = W'($urandom_range(0, 127));
      tick     = $urandom_range(0, 1);
      inc      = ($urandom_range(0, 7) == 0);
      dec      = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) run = ~run;
      if ($urandom_range(0, 31) == 0) up = ~up;
      step();
    end
    clear = 0; load = 0; tick = 0; inc = 0; dec = 0; run = 0;
    step();

    // Asynchronous reset in the middle of counting.
    load = 1; load_val = 7'd50;
    step();
    load = 0; run = 1; up = 1; tick = 1;
    step();
    step();
    chk("pre_reset_time", int'(o_time), 51);
    #1;
    chk_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_rst_time",   int'(o_time),   0);
    chk("async_rst_carry",  int'(o_carry),  0);
    chk("async_rst_borrow", int'(o_borrow), 0);
    chk("async_rst_zero",   int'(o_zero),   1);
    chk("async_rst_done",   int'(o_done),   0);
    m_cnt = 0; m_run = 1'b0; m_done = 1'b0;
    tick = 0; run = 0;
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    chk_en = 1'b1;
    step();
    chk("post_reset_time", int'(o_time), 0);
    chk_en = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
